// File: rtl/llc_mem_req_buf.sv
// Request buffer between the LLC core and memory: a small FIFO of outgoing requests
// with a cap on reads queued or outstanding, plus a combinational response pass-through.
`ifndef LINE_ADDR_BITS
`define LINE_ADDR_BITS 26
`endif
`ifndef BITS_PER_LINE
`define BITS_PER_LINE 128
`endif

module llc_mem_req_buf #(
    parameter int DEPTH  = 4,
    parameter int MAX_RD = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_in_valid,
    output logic                       req_in_ready,
    input  logic                       req_in_hwrite,
    input  logic [2:0]                 req_in_hsize,
    input  logic [1:0]                 req_in_hprot,
    input  logic [`LINE_ADDR_BITS-1:0] req_in_addr,
    input  logic [`BITS_PER_LINE-1:0]  req_in_line,
    output logic                       req_out_valid,
    input  logic                       req_out_ready,
    output logic                       req_out_hwrite,
    output logic [2:0]                 req_out_hsize,
    output logic [1:0]                 req_out_hprot,
    output logic [`LINE_ADDR_BITS-1:0] req_out_addr,
    output logic [`BITS_PER_LINE-1:0]  req_out_line,
    input  logic                       mem_rsp_valid,
    output logic                       mem_rsp_ready,
    input  logic [`BITS_PER_LINE-1:0]  mem_rsp_line,
    output logic                       rsp_out_valid,
    input  logic                       rsp_out_ready,
    output logic [`BITS_PER_LINE-1:0]  rsp_out_line,
    output logic [3:0]                 rd_cnt,
    output logic                       idle,
    output logic                       err_unexp_rsp
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PW    = 1 + 3 + 2 + `LINE_ADDR_BITS + `BITS_PER_LINE;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [3:0]       rd_cnt_reg, rd_cnt_next;
    logic             err_reg, err_next;

    logic [PW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_data;
    logic [PW-1:0]    head;

    logic full, empty, push, pop, rsp_hs, rd_inc, rd_dec;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // Ready never looks at req_out_ready: a request always spends one cycle in storage.
    assign req_in_ready = !full && (req_in_hwrite || (rd_cnt_reg < 4'(MAX_RD)));
    assign push         = req_in_valid && req_in_ready;
    assign pop          = req_out_valid && req_out_ready;

    assign rsp_out_valid = mem_rsp_valid;
    assign mem_rsp_ready = rsp_out_ready;
    assign rsp_out_line  = mem_rsp_line;
    assign rsp_hs        = rsp_out_valid && rsp_out_ready;

    assign rd_inc = push && !req_in_hwrite;
    assign rd_dec = rsp_hs && (rd_cnt_reg != 4'd0);

    assign wr_data = {req_in_hwrite, req_in_hsize, req_in_hprot, req_in_addr, req_in_line};
    assign head    = mem[rd_ptr_reg];

    assign req_out_valid = !empty;
    assign {req_out_hwrite, req_out_hsize, req_out_hprot, req_out_addr, req_out_line} = head;

    assign rd_cnt        = rd_cnt_reg;
    assign idle          = empty && (rd_cnt_reg == 4'd0);
    assign err_unexp_rsp = err_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        rd_cnt_next = rd_cnt_reg;
        err_next    = err_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end

        if (rd_inc && !rd_dec) begin
            rd_cnt_next = rd_cnt_reg + 4'd1;
        end else if (!rd_inc && rd_dec) begin
            rd_cnt_next = rd_cnt_reg - 4'd1;
        end

        // A response with nothing outstanding is flagged, never counted.
        if (rsp_hs && (rd_cnt_reg == 4'd0)) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rd_cnt_reg <= 4'd0;
            err_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            rd_cnt_reg <= rd_cnt_next;
            err_reg    <= err_next;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

endmodule

// File: tb/tb_llc_mem_req_buf.sv
// Bench for llc_mem_req_buf: per-cycle vector table plus a scoreboard monitor that
// tracks the request queue, read count and error flag.
`ifndef LINE_ADDR_BITS
`define LINE_ADDR_BITS 26
`endif
`ifndef BITS_PER_LINE
`define BITS_PER_LINE 128
`endif

module tb_llc_mem_req_buf;
    localparam int DEPTH  = 4;
    localparam int MAX_RD = 4;
    localparam int LAB    = `LINE_ADDR_BITS;
    localparam int BPL    = `BITS_PER_LINE;
    localparam int PW     = 1 + 3 + 2 + LAB + BPL;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req_in_valid = 1'b0;
    logic           req_in_ready;
    logic           req_in_hwrite = 1'b0;
    logic [2:0]     req_in_hsize = '0;
    logic [1:0]     req_in_hprot = '0;
    logic [LAB-1:0] req_in_addr = '0;
    logic [BPL-1:0] req_in_line = '0;
    logic           req_out_valid;
    logic           req_out_ready = 1'b0;
    logic           req_out_hwrite;
    logic [2:0]     req_out_hsize;
    logic [1:0]     req_out_hprot;
    logic [LAB-1:0] req_out_addr;
    logic [BPL-1:0] req_out_line;
    logic           mem_rsp_valid = 1'b0;
    logic           mem_rsp_ready;
    logic [BPL-1:0] mem_rsp_line = '0;
    logic           rsp_out_valid;
    logic           rsp_out_ready = 1'b0;
    logic [BPL-1:0] rsp_out_line;
    logic [3:0]     rd_cnt;
    logic           idle;
    logic           err_unexp_rsp;

    llc_mem_req_buf #(.DEPTH(DEPTH), .MAX_RD(MAX_RD)) dut (
        .clk(clk), .rst(rst),
        .req_in_valid(req_in_valid), .req_in_ready(req_in_ready),
        .req_in_hwrite(req_in_hwrite), .req_in_hsize(req_in_hsize),
        .req_in_hprot(req_in_hprot), .req_in_addr(req_in_addr), .req_in_line(req_in_line),
        .req_out_valid(req_out_valid), .req_out_ready(req_out_ready),
        .req_out_hwrite(req_out_hwrite), .req_out_hsize(req_out_hsize),
        .req_out_hprot(req_out_hprot), .req_out_addr(req_out_addr), .req_out_line(req_out_line),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_line(mem_rsp_line),
        .rsp_out_valid(rsp_out_valid), .rsp_out_ready(rsp_out_ready), .rsp_out_line(rsp_out_line),
        .rd_cnt(rd_cnt), .idle(idle), .err_unexp_rsp(err_unexp_rsp)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard model: expected request order, read count and sticky error.
    logic [PW-1:0] sb[$];
    int            m_rdc = 0;
    bit            m_err = 0;

    initial begin
        bit exp_irdy, push, pop, rsp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb.delete();
                m_rdc = 0;
                m_err = 0;
                chk("rst_out_valid", 192'(req_out_valid), 192'(0));
                chk("rst_idle", 192'(idle), 192'(1));
                chk("rst_rd_cnt", 192'(rd_cnt), 192'(0));
                chk("rst_err", 192'(err_unexp_rsp), 192'(0));
            end else begin
                exp_irdy = (sb.size() < DEPTH) && (req_in_hwrite || (m_rdc < MAX_RD));
                chk("mon_in_ready", 192'(req_in_ready), 192'(exp_irdy));
                chk("mon_out_valid", 192'(req_out_valid), 192'(sb.size() != 0));
                if (sb.size() != 0 && req_out_valid)
                    chk("mon_head", 192'({req_out_hwrite, req_out_hsize, req_out_hprot,
                                          req_out_addr, req_out_line}), 192'(sb[0]));
                chk("mon_rd_cnt", 192'(rd_cnt), 192'(m_rdc));
                chk("mon_err", 192'(err_unexp_rsp), 192'(m_err));
                chk("mon_idle", 192'(idle), 192'((sb.size() == 0) && (m_rdc == 0)));
                chk("mon_rsp", 192'({rsp_out_valid, mem_rsp_ready, rsp_out_line}),
                    192'({mem_rsp_valid, rsp_out_ready, mem_rsp_line}));
                push = req_in_valid && exp_irdy;
                pop  = (sb.size() != 0) && req_out_ready;
                rsp  = mem_rsp_valid && rsp_out_ready;
                if (pop) void'(sb.pop_front());
                if (push) sb.push_back({req_in_hwrite, req_in_hsize, req_in_hprot,
                                        req_in_addr, req_in_line});
                if (push && !req_in_hwrite) m_rdc++;
                if (rsp) begin
                    if (m_rdc == 0) m_err = 1;
                    else m_rdc--;
                end
            end
        end
    end

    typedef struct {
        bit v; bit w; logic [11:0] a; bit ordy; bit rv; bit rr;
        bit e_irdy; bit e_ovld; logic [3:0] e_rdc; bit e_idle; bit e_err;
    } vec_t;

    localparam int NV = 34;
    vec_t tbl[NV];

    function automatic vec_t mk(bit v, bit w, logic [11:0] a, bit ordy, bit rv, bit rr,
                                bit e_irdy, bit e_ovld, logic [3:0] e_rdc, bit e_idle, bit e_err);
        vec_t r;
        r.v = v; r.w = w; r.a = a; r.ordy = ordy; r.rv = rv; r.rr = rr;
        r.e_irdy = e_irdy; r.e_ovld = e_ovld; r.e_rdc = e_rdc; r.e_idle = e_idle; r.e_err = e_err;
        return r;
    endfunction

    task automatic drive(input bit v, input bit w, input logic [11:0] a,
                         input bit ordy, input bit rv, input bit rr);
        req_in_valid  = v;
        req_in_hwrite = w;
        req_in_addr   = LAB'(a);
        req_in_hsize  = a[2:0];
        req_in_hprot  = a[4:3];
        req_in_line   = {$urandom, $urandom, $urandom, $urandom};
        req_out_ready = ordy;
        mem_rsp_valid = rv;
        rsp_out_ready = rr;
        mem_rsp_line  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        // single read, fill/drain, read limit, push+pop+response, unexpected response
        tbl[0]  = mk(1,0,12'h100,1,0,0, 1,0,0,1,0);
        tbl[1]  = mk(0,0,12'h000,1,0,0, 1,1,1,0,0);
        tbl[2]  = mk(0,0,12'h000,1,1,1, 1,0,1,0,0);
        tbl[3]  = mk(0,0,12'h000,0,0,0, 1,0,0,1,0);
        tbl[4]  = mk(1,1,12'h200,0,0,0, 1,0,0,1,0);
        tbl[5]  = mk(1,1,12'h201,0,0,0, 1,1,0,0,0);
        tbl[6]  = mk(1,1,12'h202,0,0,0, 1,1,0,0,0);
        tbl[7]  = mk(1,1,12'h203,0,0,0, 1,1,0,0,0);
        tbl[8]  = mk(1,1,12'h204,0,0,0, 0,1,0,0,0);
        tbl[9]  = mk(0,0,12'h000,1,0,0, 0,1,0,0,0);
        tbl[10] = mk(0,0,12'h000,1,0,0, 1,1,0,0,0);
        tbl[11] = mk(0,0,12'h000,1,0,0, 1,1,0,0,0);
        tbl[12] = mk(0,0,12'h000,1,0,0, 1,1,0,0,0);
        tbl[13] = mk(0,0,12'h000,0,0,0, 1,0,0,1,0);
        tbl[14] = mk(1,0,12'h300,1,0,0, 1,0,0,1,0);
        tbl[15] = mk(1,0,12'h301,1,0,0, 1,1,1,0,0);
        tbl[16] = mk(1,0,12'h302,1,0,0, 1,1,2,0,0);
        tbl[17] = mk(1,0,12'h303,1,0,0, 1,1,3,0,0);
        tbl[18] = mk(1,0,12'h304,1,0,0, 0,1,4,0,0);
        tbl[19] = mk(1,1,12'h305,1,0,0, 1,0,4,0,0);
        tbl[20] = mk(1,0,12'h304,1,1,1, 0,1,4,0,0);
        tbl[21] = mk(1,0,12'h304,1,0,0, 1,0,3,0,0);
        tbl[22] = mk(0,0,12'h000,0,0,0, 0,1,4,0,0);
        tbl[23] = mk(0,0,12'h000,1,1,1, 0,1,4,0,0);
        tbl[24] = mk(0,0,12'h000,0,1,1, 1,0,3,0,0);
        tbl[25] = mk(1,1,12'h400,0,0,0, 1,0,2,0,0);
        tbl[26] = mk(1,0,12'h401,1,1,1, 1,1,2,0,0);
        tbl[27] = mk(0,0,12'h000,0,0,0, 1,1,2,0,0);
        tbl[28] = mk(0,0,12'h000,1,1,1, 1,1,2,0,0);
        tbl[29] = mk(0,0,12'h000,0,1,1, 1,0,1,0,0);
        tbl[30] = mk(0,0,12'h000,0,0,0, 1,0,0,1,0);
        tbl[31] = mk(0,0,12'h000,0,1,0, 1,0,0,1,0);
        tbl[32] = mk(0,0,12'h000,0,1,1, 1,0,0,1,0);
        tbl[33] = mk(0,0,12'h000,0,0,0, 1,0,0,1,1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].ordy, tbl[i].rv, tbl[i].rr);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 192'(req_in_ready), 192'(tbl[i].e_irdy));
            chk($sformatf("vec%0d_out_valid", i), 192'(req_out_valid), 192'(tbl[i].e_ovld));
            chk($sformatf("vec%0d_rd_cnt", i), 192'(rd_cnt), 192'(tbl[i].e_rdc));
            chk($sformatf("vec%0d_idle", i), 192'(idle), 192'(tbl[i].e_idle));
            chk($sformatf("vec%0d_err", i), 192'(err_unexp_rsp), 192'(tbl[i].e_err));
            if (tbl[i].e_ovld && tbl[i].ordy)
                $display("[TB] vec %0d: pop addr=%h hwrite=%0d rd_cnt=%0d",
                         i, req_out_addr, req_out_hwrite, rd_cnt);
            else
                $display("[TB] vec %0d: in_ready=%0d out_valid=%0d rd_cnt=%0d idle=%0d err=%0d",
                         i, req_in_ready, req_out_valid, rd_cnt, idle, err_unexp_rsp);
            @(posedge clk);
            #1;
        end

        // Reset pulse clears the sticky error flag.
        drive(0, 0, 12'h000, 0, 0, 0);
        rst = 1'b0;
        #1 chk("seq_rst_err_clear", 192'(err_unexp_rsp), 192'(0));
        $display("[TB] seq rst pulse: err=%0d", err_unexp_rsp);
        @(posedge clk);
        #1 rst = 1'b1;

        // Queue three writes, then reset asynchronously mid-cycle.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 12'h500 + 12'(i), 0, 0, 0);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 12'h000, 1, 0, 0);
        chk("seq_q3_out_valid", 192'(req_out_valid), 192'(1));
        rst = 1'b0;
        #1;
        chk("seq_async_out_valid", 192'(req_out_valid), 192'(0));
        chk("seq_async_idle", 192'(idle), 192'(1));
        $display("[TB] seq async reset: out_valid=%0d idle=%0d", req_out_valid, idle);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("seq_no_stale", 192'(req_out_valid), 192'(0));
            $display("[TB] seq post-reset cycle %0d: out_valid=%0d", i, req_out_valid);
        end

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
